// File: rtl/mem_port_arbiter_pkg.sv
// Shared types for the unified-memory port arbiter: transaction owner, FSM state, byte-enable mask.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        OWNER_NONE,
        OWNER_FETCH,
        OWNER_DATA
    } mem_owner_type;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_REQ,
        ARB_RESP
    } arb_state_type;

    // Wide enough for any supported DATA_W; users slice the low DATA_W/8 bits.
    localparam logic [63:0] MEM_BE_ALL = '1;

endpackage

// File: rtl/arb_priority_select.sv
// Fetch/data winner selection with a bounded data-streak counter so fetch cannot starve.
module arb_priority_select
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          arb_en,
    input  logic          if_req,
    input  logic          dm_req,
    output mem_owner_type winner
);

    localparam logic [3:0] STREAK_MAX = 4'(MAX_STREAK);

    logic [3:0] streak_q, streak_d;

    always_comb begin
        winner = OWNER_NONE;
        if (arb_en) begin
            if (dm_req && !(if_req && streak_q == STREAK_MAX)) begin
                winner = OWNER_DATA;
            end else if (if_req) begin
                winner = OWNER_FETCH;
            end
        end
    end

    always_comb begin
        streak_d = streak_q;
        if (arb_en) begin
            if (winner == OWNER_FETCH || !if_req) begin
                streak_d = '0;
            end else if (winner == OWNER_DATA && streak_q != STREAK_MAX) begin
                streak_d = streak_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            streak_q <= '0;
        end else begin
            streak_q <= streak_d;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between instruction fetch and the LSU, one transaction
// outstanding at a time, with flush-killed fetch responses discarded.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    input  logic                if_kill,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    output logic                if_stall,
    input  logic                dm_req,
    input  logic                dm_we,
    input  logic [DATA_W/8-1:0] dm_be,
    input  logic [ADDR_W-1:0]   dm_addr,
    input  logic [DATA_W-1:0]   dm_wdata,
    output logic                dm_gnt,
    output logic                dm_rvalid,
    output logic [DATA_W-1:0]   dm_rdata,
    output logic                mem_req,
    output logic                mem_we,
    output logic [DATA_W/8-1:0] mem_be,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic                mem_gnt,
    input  logic                mem_rvalid,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int unsigned BE_W = DATA_W / 8;
    localparam logic [BE_W-1:0] BE_ALL = MEM_BE_ALL[BE_W-1:0];

    arb_state_type       state_q, state_d;
    mem_owner_type       owner_q, owner_d;
    mem_owner_type       winner;
    logic                killed_q, killed_d;
    logic                mem_we_q, mem_we_d;
    logic [BE_W-1:0]     mem_be_q, mem_be_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic                arb_en;
    logic                resp_fire;

    // Gating with reset_n keeps the combinational grants quiet while reset is held.
    assign arb_en = (state_q == ARB_IDLE) && reset_n;

    arb_priority_select #(
        .MAX_STREAK (MAX_STREAK)
    ) u_prio (
        .clk     (clk),
        .reset_n (reset_n),
        .arb_en  (arb_en),
        .if_req  (if_req),
        .dm_req  (dm_req),
        .winner  (winner)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        killed_d    = killed_q;
        mem_we_d    = mem_we_q;
        mem_be_d    = mem_be_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        unique case (state_q)
            ARB_IDLE: begin
                if (winner == OWNER_FETCH) begin
                    owner_d     = OWNER_FETCH;
                    killed_d    = if_kill;
                    mem_we_d    = 1'b0;
                    mem_be_d    = BE_ALL;
                    mem_addr_d  = if_addr;
                    mem_wdata_d = '0;
                    state_d     = ARB_REQ;
                end else if (winner == OWNER_DATA) begin
                    owner_d     = OWNER_DATA;
                    mem_we_d    = dm_we;
                    mem_be_d    = dm_be;
                    mem_addr_d  = dm_addr;
                    mem_wdata_d = dm_wdata;
                    state_d     = ARB_REQ;
                end
            end
            ARB_REQ: begin
                if (if_kill && owner_q == OWNER_FETCH) killed_d = 1'b1;
                if (mem_gnt) state_d = ARB_RESP;
            end
            ARB_RESP: begin
                if (if_kill && owner_q == OWNER_FETCH) killed_d = 1'b1;
                if (mem_rvalid) begin
                    state_d  = ARB_IDLE;
                    owner_d  = OWNER_NONE;
                    killed_d = 1'b0;
                end
            end
            default: state_d = ARB_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ARB_IDLE;
            owner_q     <= OWNER_NONE;
            killed_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_be_q    <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            killed_q    <= killed_d;
            mem_we_q    <= mem_we_d;
            mem_be_q    <= mem_be_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign resp_fire = (state_q == ARB_RESP) && mem_rvalid;

    always_comb begin
        if_gnt    = (winner == OWNER_FETCH);
        dm_gnt    = (winner == OWNER_DATA);
        // A kill arriving together with the response still discards it.
        if_rvalid = resp_fire && owner_q == OWNER_FETCH && !killed_q && !if_kill;
        dm_rvalid = resp_fire && owner_q == OWNER_DATA;
        if_rdata  = if_rvalid ? mem_rdata : '0;
        dm_rdata  = dm_rvalid ? mem_rdata : '0;
        if_stall  = reset_n && if_req && !if_rvalid;
    end

    assign mem_req   = (state_q == ARB_REQ);
    assign mem_we    = mem_we_q;
    assign mem_be    = mem_be_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

    a_rvalid_in_resp: assert property (
        @(posedge clk) disable iff (!reset_n) mem_rvalid |-> (state_q == ARB_RESP)
    );

endmodule
